// File: rtl/matrix_adder.sv
// matrix_adder: registered element-wise adder for two ROWS x COLS matrices of
// unsigned BITLENGTH-bit elements carried on flattened packed buses.
//
// Element (r,c) (0-based here) sits at bits [(r*COLS+c)*BITLENGTH +: BITLENGTH],
// with element (0,0) at the LSBs. Its carry flag is at ovf[r*COLS+c].
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears c_out, ovf and out_valid
//   in_valid   a_in/b_in carry a valid operand pair this cycle
//   a_in       packed matrix A
//   b_in       packed matrix B
//   out_valid  c_out/ovf hold a new result (one cycle after in_valid)
//   c_out      packed matrix C = A + B (modulo or saturated, see below)
//   ovf        per-element carry-out of the BITLENGTH-bit add
//
// Build option: define MATRIX_ADDER_SAT_EN to saturate every element to all
// ones on carry-out instead of wrapping. Timing and handshake are unchanged.

module matrix_adder #(
    parameter int unsigned BITLENGTH = 8,
    parameter int unsigned ROWS      = 7,
    parameter int unsigned COLS      = 7
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic [ROWS*COLS*BITLENGTH-1:0]  a_in,
    input  logic [ROWS*COLS*BITLENGTH-1:0]  b_in,
    output logic                            out_valid,
    output logic [ROWS*COLS*BITLENGTH-1:0]  c_out,
    output logic [ROWS*COLS-1:0]            ovf
);

    localparam int unsigned NELEM = ROWS * COLS;
    localparam int unsigned WIDTH = NELEM * BITLENGTH;

    logic [WIDTH-1:0] c_d;
    logic [WIDTH-1:0] c_q;
    logic [NELEM-1:0] ovf_d;
    logic [NELEM-1:0] ovf_q;
    logic             valid_q;

    // Independent per-element adders; one extra bit captures the carry-out.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int unsigned IDX = r * COLS + c;
            localparam int unsigned LSB = IDX * BITLENGTH;

            logic [BITLENGTH:0] sum;

            assign sum        = {1'b0, a_in[LSB +: BITLENGTH]} + {1'b0, b_in[LSB +: BITLENGTH]};
            assign ovf_d[IDX] = sum[BITLENGTH];
`ifdef MATRIX_ADDER_SAT_EN
            assign c_d[LSB +: BITLENGTH] = sum[BITLENGTH] ? {BITLENGTH{1'b1}} : sum[BITLENGTH-1:0];
`else
            assign c_d[LSB +: BITLENGTH] = sum[BITLENGTH-1:0];
`endif
        end
    end

    // Result registers load only on a valid pair; valid is a one-stage pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                c_q   <= c_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign c_out     = c_q;
    assign ovf       = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_matrix_adder.sv
// tb_matrix_adder: directed self-checking bench for matrix_adder, covering the
// default 8/7/7 build and a 4-bit 2x3 instance for packing and overflow.
// Expected values follow the build: MATRIX_ADDER_SAT_EN selects saturation.

module tb_matrix_adder;

    localparam int unsigned BL  = 8;
    localparam int unsigned NR  = 7;
    localparam int unsigned NC  = 7;
    localparam int unsigned NE  = NR * NC;
    localparam int unsigned W   = NE * BL;

    localparam int unsigned SBL = 4;
    localparam int unsigned SNR = 2;
    localparam int unsigned SNC = 3;
    localparam int unsigned SNE = SNR * SNC;
    localparam int unsigned SW  = SNE * SBL;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [W-1:0]    a_in;
    logic [W-1:0]    b_in;
    logic            out_valid;
    logic [W-1:0]    c_out;
    logic [NE-1:0]   ovf;

    logic            s_in_valid;
    logic [SW-1:0]   s_a_in;
    logic [SW-1:0]   s_b_in;
    logic            s_out_valid;
    logic [SW-1:0]   s_c_out;
    logic [SNE-1:0]  s_ovf;

    int unsigned n_chk;
    int unsigned n_bad;

    logic [W-1:0]    exp_c;
    logic [NE-1:0]   exp_ovf;
    logic [SW-1:0]   s_exp_c;

    matrix_adder #(.BITLENGTH(BL), .ROWS(NR), .COLS(NC)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    matrix_adder #(.BITLENGTH(SBL), .ROWS(SNR), .COLS(SNC)) u_dut_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .a_in      (s_a_in),
        .b_in      (s_b_in),
        .out_valid (s_out_valid),
        .c_out     (s_c_out),
        .ovf       (s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BL-1:0] elem(input logic [W-1:0] bus, input int r, input int c);
        return bus[((r - 1) * NC + (c - 1)) * BL +: BL];
    endfunction

    task automatic fill_all(input logic [BL-1:0] av, input logic [BL-1:0] bv);
        for (int i = 0; i < int'(NE); i++) begin
            a_in[i * BL +: BL] = av;
            b_in[i * BL +: BL] = bv;
        end
    endtask

    initial begin
        n_chk      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        s_in_valid = 1'b0;
        a_in       = '0;
        b_in       = '0;
        s_a_in     = '0;
        s_b_in     = '0;

        // Reset state with reset held from time 0
        #2;
        check_val("rst_valid", 512'(out_valid), 512'(0));
        check_val("rst_c",     512'(c_out),     512'(0));
        check_val("rst_ovf",   512'(ovf),       512'(0));
        tick();
        rst_n = 1'b1;

        // Baseline sum: A=2r+c, B=2r+c+1, C=4r+2c+1; small DUT A=r+c, B=15
        for (int r = 1; r <= int'(NR); r++) begin
            for (int c = 1; c <= int'(NC); c++) begin
                a_in[((r - 1) * NC + (c - 1)) * BL +: BL]  = BL'(2 * r + c);
                b_in[((r - 1) * NC + (c - 1)) * BL +: BL]  = BL'(2 * r + c + 1);
                exp_c[((r - 1) * NC + (c - 1)) * BL +: BL] = BL'(4 * r + 2 * c + 1);
            end
        end
        for (int r = 1; r <= int'(SNR); r++) begin
            for (int c = 1; c <= int'(SNC); c++) begin
                s_a_in[((r - 1) * SNC + (c - 1)) * SBL +: SBL] = SBL'(r + c);
                s_b_in[((r - 1) * SNC + (c - 1)) * SBL +: SBL] = SBL'(15);
`ifdef MATRIX_ADDER_SAT_EN
                s_exp_c[((r - 1) * SNC + (c - 1)) * SBL +: SBL] = SBL'(15);
`else
                s_exp_c[((r - 1) * SNC + (c - 1)) * SBL +: SBL] = SBL'(r + c - 1);
`endif
            end
        end
        in_valid   = 1'b1;
        s_in_valid = 1'b1;
        tick();
        in_valid   = 1'b0;
        s_in_valid = 1'b0;
        check_val("base_valid", 512'(out_valid), 512'(1));
        check_val("base_c11", 512'(elem(c_out, 1, 1)), 512'(7));
        check_val("base_c77", 512'(elem(c_out, 7, 7)), 512'(43));
        check_val("base_c35", 512'(elem(c_out, 3, 5)), 512'(23));
        for (int r = 1; r <= int'(NR); r++) begin
            for (int c = 1; c <= int'(NC); c++) begin
                check_val($sformatf("base_c(%0d,%0d)", r, c),
                          512'(elem(c_out, r, c)), 512'(4 * r + 2 * c + 1));
            end
        end
        check_val("base_ovf", 512'(ovf), 512'(0));
        check_val("small_valid", 512'(s_out_valid), 512'(1));
`ifdef MATRIX_ADDER_SAT_EN
        check_val("small_c11", 512'(s_c_out[3:0]), 512'(15));
`else
        check_val("small_c11", 512'(s_c_out[3:0]), 512'(1));
`endif
        check_val("small_c_bus", 512'(s_c_out), 512'(s_exp_c));
        check_val("small_ovf",   512'(s_ovf),   512'(6'b111111));

        // Hold: in_valid low with scrambled operands
        for (int i = 0; i < int'(W); i += 32) begin
            a_in[i +: 8] = 8'($urandom);
            b_in[i +: 8] = 8'($urandom);
        end
        a_in[W-1 -: 32] = $urandom;
        b_in[W-1 -: 32] = $urandom;
        tick();
        check_val("hold_valid", 512'(out_valid), 512'(0));
        check_val("hold_c",     512'(c_out),     512'(exp_c));
        check_val("hold_ovf",   512'(ovf),       512'(0));
        check_val("small_hold_c", 512'(s_c_out), 512'(s_exp_c));

        // Overflow: (2,4)=200+100 and (1,1)=255+0
        fill_all(8'd0, 8'd0);
        a_in[((2 - 1) * NC + (4 - 1)) * BL +: BL] = 8'd200;
        b_in[((2 - 1) * NC + (4 - 1)) * BL +: BL] = 8'd100;
        a_in[0 +: BL] = 8'd255;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_val("ovf_valid", 512'(out_valid), 512'(1));
`ifdef MATRIX_ADDER_SAT_EN
        check_val("ovf_c24", 512'(elem(c_out, 2, 4)), 512'(255));
`else
        check_val("ovf_c24", 512'(elem(c_out, 2, 4)), 512'(44));
`endif
        check_val("ovf_c11",  512'(elem(c_out, 1, 1)), 512'(255));
        check_val("ovf_c12",  512'(elem(c_out, 1, 2)), 512'(0));
        exp_ovf     = '0;
        exp_ovf[10] = 1'b1;
        check_val("ovf_mask", 512'(ovf), 512'(exp_ovf));

        // Streaming: three back-to-back valid pairs
        fill_all(8'd255, 8'd1);
        in_valid = 1'b1;
        tick();
        fill_all(8'd0, 8'd0);
        check_val("s1_valid", 512'(out_valid), 512'(1));
`ifdef MATRIX_ADDER_SAT_EN
        for (int i = 0; i < int'(NE); i++) exp_c[i * BL +: BL] = 8'd255;
`else
        exp_c = '0;
`endif
        check_val("s1_c",   512'(c_out), 512'(exp_c));
        check_val("s1_ovf", 512'(ovf),   512'({NE{1'b1}}));
        tick();
        fill_all(8'd10, 8'd20);
        check_val("s2_valid", 512'(out_valid), 512'(1));
        check_val("s2_c",     512'(c_out),     512'(0));
        check_val("s2_ovf",   512'(ovf),       512'(0));
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < int'(NE); i++) exp_c[i * BL +: BL] = 8'd30;
        check_val("s3_valid", 512'(out_valid), 512'(1));
        check_val("s3_c",     512'(c_out),     512'(exp_c));
        check_val("s3_ovf",   512'(ovf),       512'(0));
        tick();
        check_val("s4_valid", 512'(out_valid), 512'(0));
        check_val("s4_c",     512'(c_out),     512'(exp_c));

        // Mid-stream reset: asynchronous clear between edges, pending pair dropped
        fill_all(8'd250, 8'd9);
        in_valid = 1'b1;
        tick();
        check_val("pre_rst_valid", 512'(out_valid), 512'(1));
        check_val("pre_rst_ovf",   512'(ovf),       512'({NE{1'b1}}));
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 512'(out_valid), 512'(0));
        check_val("mid_rst_c",     512'(c_out),     512'(0));
        check_val("mid_rst_ovf",   512'(ovf),       512'(0));
        check_val("mid_rst_small", 512'(s_c_out),   512'(0));
        tick();
        check_val("rst_edge_valid", 512'(out_valid), 512'(0));
        check_val("rst_edge_c",     512'(c_out),     512'(0));
        rst_n = 1'b1;

        // First edge after release captures
        fill_all(8'd3, 8'd4);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < int'(NE); i++) exp_c[i * BL +: BL] = 8'd7;
        check_val("post_rst_valid", 512'(out_valid), 512'(1));
        check_val("post_rst_c",     512'(c_out),     512'(exp_c));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
